alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/simd_pkg.sv | 29 ++
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD vector datapath: ALU opcodes,
// sequencer states and default geometry.
package simd_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int ADDR_WIDTH   = 6;
    localparam int LEN_WIDTH    = 5;
    localparam int MAX_LEN      = 16;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [2:0] {
        OP_NOOP          = 3'd0,
        OP_ADD           = 3'd1,
        OP_SUB           = 3'd2,
        OP_MUL           = 3'd3,
        OP_DOTP          = 3'd4,
        OP_STORE_TEMP_S1 = 3'd5,
        OP_STORE_TEMP_S2 = 3'd6,
        OP_STORE_RESULT  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Vector command sequencer: issues operand reads, feeds an external ALU through
// a 2-stage valid pipeline and writes element results or a dot-product sum.
module alu_sequencer #(
    parameter int OPCODE_WIDTH = simd_pkg::OPCODE_WIDTH,
    parameter int ADDR_WIDTH   = simd_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH    = simd_pkg::LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_a,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_b,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   rd_addr_b,
    input  logic [31:0]             rd_data_a,
    input  logic [31:0]             rd_data_b,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [31:0]             alu_out,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [31:0]             wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    import simd_pkg::*;

    seq_state_e              state_q, state_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d;
    logic [LEN_WIDTH-1:0]    widx_q, widx_d;
    logic [ADDR_WIDTH-1:0]   src_a_q, src_a_d;
    logic [ADDR_WIDTH-1:0]   src_b_q, src_b_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic                    err_q, err_d;
    logic [31:0]             acc_q, acc_d;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic                    fw_q, fw_d;

    logic                    is_dotp;
    logic                    cmd_reject;
    logic [LEN_WIDTH-1:0]    len_clamped;

    assign is_dotp    = (op_q == OPCODE_WIDTH'(OP_DOTP));
    assign cmd_reject = (cmd_opcode >= OPCODE_WIDTH'(OP_STORE_TEMP_S1));
    assign len_clamped = (cmd_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : cmd_len;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        len_d     = len_q;
        idx_d     = idx_q;
        widx_d    = widx_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        dst_d     = dst_q;
        err_d     = err_q;
        acc_d     = acc_q;
        v1_d      = (state_q == ST_RUN);
        v2_d      = v1_q;
        fw_d      = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        rd_en     = 1'b0;

        // Result stage: a dot product folds into acc, element ops advance the write index.
        if (v2_q) begin
            if (is_dotp) begin
                acc_d = acc_q + alu_out;
            end else begin
                widx_d = widx_q + LEN_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d    = cmd_opcode;
                    len_d   = len_clamped;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    idx_d   = '0;
                    widx_d  = '0;
                    acc_d   = '0;
                    err_d   = cmd_reject;
                    if (cmd_reject || cmd_opcode == OPCODE_WIDTH'(OP_NOOP) || len_clamped == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rd_en = 1'b1;
                idx_d = idx_q + LEN_WIDTH'(1);
                if (idx_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // v2 without v1 marks the last element leaving the pipeline.
                if (is_dotp) begin
                    if (fw_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        fw_d = v2_q && !v1_q;
                    end
                end else if (v2_q && !v1_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = OPCODE_WIDTH'(OP_NOOP);
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        if (rd_en) begin
            rd_addr_a = src_a_q + ADDR_WIDTH'(idx_q);
            rd_addr_b = src_b_q + ADDR_WIDTH'(idx_q);
        end
        if (v1_q) begin
            alu_a      = rd_data_a;
            alu_b      = rd_data_b;
            alu_opcode = op_q;
        end
        if (v2_q && !is_dotp) begin
            wr_en   = 1'b1;
            wr_addr = dst_q + ADDR_WIDTH'(widx_q);
            wr_data = alu_out;
        end else if (fw_q) begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            wr_data = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            widx_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            fw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            widx_q  <= widx_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            fw_q    <= fw_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural register file and ALU,
// a cycle-indexed expectation model, directed corner cases and random commands.
module tb_alu_sequencer;
    import simd_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [4:0]  cmd_len;
    logic [5:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic        rd_en;
    logic [5:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;

    always #5 clk = ~clk;

    alu_sequencer #(.OPCODE_WIDTH(3), .ADDR_WIDTH(6), .LEN_WIDTH(5)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    // Register file and ALU stand-ins, each with one cycle of latency.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end else begin
            rd_data_a <= $urandom;
            rd_data_b <= $urandom;
        end
        case (alu_opcode)
            3'd1:    alu_out <= alu_a + alu_b;
            3'd2:    alu_out <= alu_a - alu_b;
            3'd3:    alu_out <= alu_a * alu_b;
            3'd4:    alu_out <= alu_a * alu_b;
            default: alu_out <= 32'd0;
        endcase
    end

    typedef struct packed { logic [5:0] a; logic [5:0] b; } rd_t;
    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] op; } alu_t;
    typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { int c; logic [5:0] addr; logic [31:0] data; } wlog_t;

    rd_t  exp_rd   [int];
    alu_t exp_alu  [int];
    wr_t  exp_wr   [int];
    bit   exp_busy [int];
    bit   exp_done [int];
    bit   exp_err  [int];
    int   free_cyc;

    wlog_t wlog[$];
    int    dlog[$];
    int    rlog[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    // Expected per-cycle behaviour of one accepted command, from the timing rules.
    task automatic schedule(input int op, input int len, input int sa, input int sb,
                            input int d, input int c);
        int L, dn;
        logic [31:0] a, b, r, sum;
        logic [5:0] ia, ib, iw;
        L = (len > 16) ? 16 : len;
        if (op >= 5 || op == 0 || L == 0) begin
            dn = c + 1;
            if (op >= 5) exp_err[dn] = 1'b1;
        end else begin
            sum = 32'd0;
            for (int i = 0; i < L; i++) begin
                ia = 6'(sa + i);
                ib = 6'(sb + i);
                iw = 6'(d + i);
                a = mem_a[ia];
                b = mem_b[ib];
                case (op)
                    1:       r = a + b;
                    2:       r = a - b;
                    default: r = a * b;
                endcase
                exp_rd[c + 1 + i]  = '{a: ia, b: ib};
                exp_alu[c + 2 + i] = '{a: a, b: b, op: 3'(op)};
                if (op == 4) sum = sum + r;
                else exp_wr[c + 3 + i] = '{addr: iw, data: r};
            end
            if (op == 4) begin
                exp_wr[c + 3 + L] = '{addr: 6'(d), data: sum};
                dn = c + 4 + L;
            end else begin
                dn = c + 3 + L;
            end
        end
        for (int k = c + 1; k <= dn; k++) exp_busy[k] = 1'b1;
        exp_done[dn] = 1'b1;
        free_cyc = dn + 1;
    endtask

    task automatic purge(input int from);
        for (int k = from; k < from + 64; k++) begin
            exp_rd.delete(k); exp_alu.delete(k); exp_wr.delete(k);
            exp_busy.delete(k); exp_done.delete(k); exp_err.delete(k);
        end
    endtask

    task automatic compare();
        bit eb;
        alu_t ea;
        eb = exp_busy.exists(cyc);
        chk("cmd_ready", cmd_ready, !eb);
        chk("busy", busy, eb);
        chk("done", done, exp_done.exists(cyc));
        chk("err", err, exp_err.exists(cyc));
        chk("rd_en", rd_en, exp_rd.exists(cyc));
        if (exp_rd.exists(cyc))
            chk("rd_addr", {rd_addr_a, rd_addr_b}, {exp_rd[cyc].a, exp_rd[cyc].b});
        if (exp_alu.exists(cyc)) begin
            ea = exp_alu[cyc];
            chk("alu_ab", {alu_a, alu_b}, {ea.a, ea.b});
            chk("alu_op", alu_opcode, ea.op);
        end else begin
            chk("alu_bubble_ab", {alu_a, alu_b}, 64'd0);
            chk("alu_bubble_op", alu_opcode, 3'd0);
        end
        chk("wr_en", wr_en, exp_wr.exists(cyc));
        if (exp_wr.exists(cyc))
            chk("wr_addr_data", {wr_addr, wr_data}, {exp_wr[cyc].addr, exp_wr[cyc].data});
        if (!rstn) begin
            chk("rst_rd_addr", {rd_addr_a, rd_addr_b}, 64'd0);
            chk("rst_wr", {wr_addr, wr_data}, 64'd0);
        end
        if (wr_en) wlog.push_back('{c: cyc, addr: wr_addr, data: wr_data});
        if (done) dlog.push_back(cyc);
        if (rd_en) rlog.push_back(cyc);
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete(); dlog.delete(); rlog.delete();
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc) step();
    endtask

    task automatic issue(input int op, input int len, input int sa, input int sb,
                         input int d, output int acc_c);
        cmd_valid  = 1'b1;
        cmd_opcode = 3'(op);
        cmd_len    = 5'(len);
        cmd_src_a  = 6'(sa);
        cmd_src_b  = 6'(sb);
        cmd_dst    = 6'(d);
        acc_c = (cyc > free_cyc) ? cyc : free_cyc;
        schedule(op, len, sa, sb, d, acc_c);
        while (cyc <= acc_c) step();
        cmd_valid  = 1'b0;
        cmd_opcode = 3'($urandom);
        cmd_len    = 5'($urandom);
    endtask

    initial begin
        int t, t2, dfirst;
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = '0; cmd_len = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        for (int k = 0; k < 64; k++) begin mem_a[k] = $urandom; mem_b[k] = $urandom; end
        free_cyc = 0;
        repeat (3) step();
        rstn = 1'b1;
        free_cyc = cyc;
        repeat (2) step();

        // Element-wise ADD with literal results.
        for (int k = 0; k < 4; k++) begin mem_a[k] = k + 1; mem_b[8 + k] = 10 * (k + 1); end
        clear_logs();
        issue(1, 4, 0, 8, 16, t);
        wait_idle(); step();
        chk("add_nwr", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            chk("add_wr", {wlog[k].c, wlog[k].addr, wlog[k].data}, {t + 3 + k, 6'(16 + k), 32'(11 * (k + 1))});
        chk("add_done", (dlog.size() > 0) ? dlog[0] : -1, t + 7);

        // Dot product produces a single write of the sum.
        mem_a[20] = 1; mem_a[21] = 2; mem_a[22] = 3;
        mem_b[40] = 4; mem_b[41] = 5; mem_b[42] = 6;
        clear_logs();
        issue(4, 3, 20, 40, 5, t);
        wait_idle(); step();
        chk("dotp_nwr", wlog.size(), 1);
        if (wlog.size() > 0) chk("dotp_wr", {wlog[0].c, wlog[0].addr, wlog[0].data}, {t + 6, 6'd5, 32'd32});
        chk("dotp_done", (dlog.size() > 0) ? dlog[0] : -1, t + 7);

        // Write address wraps modulo 64.
        clear_logs();
        issue(2, 4, 3, 7, 62, t);
        wait_idle(); step();
        chk("wrap_nwr", wlog.size(), 4);
        if (wlog.size() == 4)
            chk("wrap_addrs", {wlog[0].addr, wlog[1].addr, wlog[2].addr, wlog[3].addr}, {6'd62, 6'd63, 6'd0, 6'd1});

        // Rejected opcode and empty commands.
        clear_logs();
        issue(6, 4, 0, 0, 0, t);
        wait_idle(); step();
        chk("rej_done", (dlog.size() > 0) ? dlog[0] : -1, t + 1);
        chk("rej_no_rw", rlog.size() + wlog.size(), 0);
        clear_logs();
        issue(1, 0, 0, 0, 0, t);
        wait_idle(); step();
        chk("len0_done", (dlog.size() > 0) ? dlog[0] : -1, t + 1);
        chk("len0_no_rw", rlog.size() + wlog.size(), 0);

        // Over-long length clamps to 16 elements.
        clear_logs();
        issue(3, 25, 10, 30, 0, t);
        wait_idle(); step();
        chk("clamp_nwr", wlog.size(), 16);

        // Reset in the middle of a MUL.
        clear_logs();
        issue(3, 8, 0, 0, 32, t);
        while (cyc < t + 3) step();
        rstn = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        purge(cyc);
        step(); step();
        rstn = 1'b1;
        free_cyc = cyc;
        repeat (12) step();
        chk("rst_no_wr", wlog.size(), 0);

        // Command held valid while busy is taken only after the previous one ends.
        clear_logs();
        issue(1, 16, 0, 16, 0, t);
        issue(1, 2, 40, 50, 20, t2);
        wait_idle(); step();
        dfirst = (dlog.size() > 0) ? dlog[0] : -1;
        chk("hold_done1", dfirst, t + 19);
        chk("hold_rd2", (rlog.size() > 16) ? rlog[16] : -1, dfirst + 2);
        chk("hold_nwr", wlog.size(), 18);
        if (wlog.size() == 18) chk("hold_no_overlap", wlog[16].c > wlog[15].c + 2, 1'b1);

        // Random commands, some back-to-back, some with fresh register contents.
        for (int n = 0; n < 60; n++) begin
            int op;
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) step();
                for (int k = 0; k < 64; k++) begin mem_a[k] = $urandom; mem_b[k] = $urandom; end
            end
            op = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
            issue(op, $urandom_range(0, 20), $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 63), t);
        end
        wait_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
